// File: rtl/cla_pkg.sv
// Shared constants and group lookahead helper for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int   GROUP_W = 4;
    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef struct packed {
        logic g;
        logic p;
    } grp_gp_t;

    // Group generate/propagate of a 4-bit slice; bit propagate is a^b.
    function automatic grp_gp_t grp_lookahead(input logic [GROUP_W-1:0] a,
                                              input logic [GROUP_W-1:0] b);
        grp_gp_t          r;
        logic [GROUP_W-1:0] bg;
        logic [GROUP_W-1:0] bp;
        bg  = a & b;
        bp  = a ^ b;
        r.p = &bp;
        r.g = bg[3]
            | (bp[3] & bg[2])
            | (bp[3] & bp[2] & bg[1])
            | (bp[3] & bp[2] & bp[1] & bg[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_cla4_group.sv
// Combinational 4-bit carry-lookahead slice: group g/p plus the slice sum for a given carry-in.
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c_in,
    output logic               g,
    output logic               p,
    output logic [GROUP_W-1:0] sum
);

    logic [GROUP_W-1:0] bg;
    logic [GROUP_W-1:0] bp;
    logic [GROUP_W-1:0] carry;
    grp_gp_t            gp;

    always_comb begin
        bg       = a & b;
        bp       = a ^ b;
        carry[0] = c_in;
        carry[1] = bg[0] | (bp[0] & c_in);
        carry[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & c_in);
        carry[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                 | (bp[2] & bp[1] & bp[0] & c_in);
        gp       = grp_lookahead(a, b);
        g        = gp.g;
        p        = gp.p;
        sum      = bp ^ carry;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage valid/ready adder/subtractor: S1 captures operands and group g/p,
// S2 resolves group carries by lookahead and registers sum and flags.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NG = WIDTH / GROUP_W;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s1_cin_q, s1_cin_d;
    logic [NG-1:0]    s1_g_q, s1_g_d;
    logic [NG-1:0]    s1_p_q, s1_p_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             s1_advance;
    logic             s2_advance;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_c;
    logic [WIDTH-1:0] grp_sum;
    logic             carry_out;
    logic [NG-1:0]    unused_grp_g;
    logic [NG-1:0]    unused_grp_p;

    // Ready depends only on registered state, never on in_valid.
    always_comb begin
        s2_advance = !out_valid_q || out_ready;
        s1_advance = !s1_valid_q || s2_advance;
        accept     = in_valid && s1_advance;
        in_ready   = !s1_valid_q || s1_advance;
    end

    always_comb begin
        b_eff   = (op == OP_SUB) ? ~b : b;
        cin_eff = (op == OP_SUB) ? 1'b1 : c_in;
    end

    for (genvar gi = 0; gi < NG; gi++) begin : g_s1_gp
        assign {grp_g[gi], grp_p[gi]} =
            grp_lookahead(a[gi*GROUP_W +: GROUP_W], b_eff[gi*GROUP_W +: GROUP_W]);
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s1_g_d     = s1_g_q;
        s1_p_d     = s1_p_q;
        if (s1_advance) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_a_d   = a;
            s1_b_d   = b_eff;
            s1_cin_d = cin_eff;
            s1_g_d   = grp_g;
            s1_p_d   = grp_p;
        end
    end

    // Group-level lookahead: each group's carry-in from the registered g/p.
    always_comb begin : s2_carry
        logic carry;
        carry = s1_cin_q;
        grp_c = '0;
        for (int i = 0; i < NG; i++) begin
            grp_c[i] = carry;
            carry    = s1_g_q[i] | (s1_p_q[i] & carry);
        end
        carry_out = carry;
    end

    // The slices' own g/p duplicate the registered S1 values and are not needed here.
    for (genvar gi = 0; gi < NG; gi++) begin : g_s2_sum
        cla4_group u_grp (
            .a    (s1_a_q[gi*GROUP_W +: GROUP_W]),
            .b    (s1_b_q[gi*GROUP_W +: GROUP_W]),
            .c_in (grp_c[gi]),
            .g    (unused_grp_g[gi]),
            .p    (unused_grp_p[gi]),
            .sum  (grp_sum[gi*GROUP_W +: GROUP_W])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (s2_advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d   = grp_sum;
                c_out_d = carry_out;
                ovf_d   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1])
                        && (grp_sum[WIDTH-1] != s1_a_q[WIDTH-1]);
                zero_d  = (grp_sum == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_cin_q    <= 1'b0;
            s1_g_q      <= '0;
            s1_p_q      <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_cin_q    <= s1_cin_d;
            s1_g_q      <= s1_g_d;
            s1_p_q      <= s1_p_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=16): directed vectors, backpressure and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_cla_pipe_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         op = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    res_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycles = 0;
    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_sum;
    logic        s_cout;
    logic        s_ovf;
    logic        s_zero;

    // Reference: plain integer arithmetic, overflow judged on the true signed result.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic mop);
        res_t               r;
        logic [31:0]        full;
        int                 sres;
        logic signed [15:0] sa;
        logic signed [15:0] sb;
        sa = ma;
        sb = mb;
        if (mop) begin
            full = 32'(ma) + 32'h0001_0000 - 32'(mb);
            sres = int'(sa) - int'(sb);
        end else begin
            full = 32'(ma) + 32'(mb) + 32'(mcin);
            sres = int'(sa) + int'(sb) + int'(mcin);
        end
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (sres > 32767) || (sres < -32768);
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cycles);
        end
    endtask

    // One clock: sample at negedge, score handshakes, then step past the rising edge.
    task automatic cycle();
        res_t e;
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_sum       = sum;
        s_cout      = c_out;
        s_ovf       = ovf;
        s_zero      = zero;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (s_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(s_out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard", 32'({s_sum, s_cout, s_ovf, s_zero}),
                        32'({e.sum, e.cout, e.ovf, e.zero}));
                end
            end
            if (in_valid && s_in_ready) begin
                exp_q.push_back(model(a, b, c_in, op));
            end
        end
        @(posedge clk);
        #1;
        cycles++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        res_t        bp_exp[4];
        logic [15:0] bp_a[4];
        logic [15:0] bp_b[4];

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{16'h0FFF, 16'hF000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (3) cycle();
        chk("reset_outputs", 32'({s_out_valid, s_sum, s_cout, s_ovf, s_zero}), 32'd0);
        rst_n = 1'b1;
        cycle();
        chk("ready_after_reset", 32'(s_in_ready), 32'd1);

        // Directed vectors, one at a time, with latency checks
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; c_in = vecs[i].cin; op = vecs[i].op;
            in_valid = 1'b1;
            cycle();
            chk("vec_accept", 32'(s_in_ready), 32'd1);
            in_valid = 1'b0;
            cycle();
            chk("vec_latency_early", 32'(s_out_valid), 32'd0);
            cycle();
            chk("vec_latency_valid", 32'(s_out_valid), 32'd1);
            chk("vec_result", 32'({s_sum, s_cout, s_ovf, s_zero}),
                32'({vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero}));
            $display("vec %0d: a=%h b=%h cin=%0d op=%0d -> sum=%h c_out=%0d ovf=%0d zero=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, s_sum, s_cout, s_ovf, s_zero);
        end

        // Backpressure: two accepted, then stall with stable outputs, then drain in order
        for (int k = 0; k < 4; k++) begin
            bp_a[k]   = 16'h1111 * 16'(k + 1);
            bp_b[k]   = 16'h0F0F + 16'(k);
            bp_exp[k] = model(bp_a[k], bp_b[k], 1'b0, 1'b0);
        end
        out_ready = 1'b0;
        op = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        a = bp_a[0]; b = bp_b[0];
        cycle();
        chk("bp_accept0", 32'(s_in_ready), 32'd1);
        a = bp_a[1]; b = bp_b[1];
        cycle();
        chk("bp_accept1", 32'(s_in_ready), 32'd1);
        a = bp_a[2]; b = bp_b[2];
        for (int h = 0; h < 2; h++) begin
            cycle();
            chk("bp_stall_ready", 32'(s_in_ready), 32'd0);
            chk("bp_hold_valid", 32'(s_out_valid), 32'd1);
            chk("bp_hold_value", 32'({s_sum, s_cout, s_ovf, s_zero}),
                32'({bp_exp[0].sum, bp_exp[0].cout, bp_exp[0].ovf, bp_exp[0].zero}));
        end
        chk("bp_accepted_count", 32'(exp_q.size()), 32'd2);
        out_ready = 1'b1;
        cycle();
        chk("bp_full_take_accept", 32'(s_in_ready), 32'd1);
        chk("bp_out0", 32'(s_out_valid), 32'd1);
        a = bp_a[3]; b = bp_b[3];
        cycle();
        chk("bp_accept3", 32'(s_in_ready), 32'd1);
        chk("bp_out1", 32'(s_out_valid), 32'd1);
        in_valid = 1'b0;
        cycle();
        chk("bp_out2", 32'({s_out_valid, s_sum}), 32'({1'b1, bp_exp[2].sum}));
        cycle();
        chk("bp_out3", 32'({s_out_valid, s_sum}), 32'({1'b1, bp_exp[3].sum}));
        cycle();
        chk("bp_drained", 32'({s_out_valid, 8'(exp_q.size())}), 32'd0);
        $display("backpressure sequence done at cycle %0d", cycles);

        // Reset with two operations in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h4321; b = 16'h1111;
        cycle();
        a = 16'hAAAA; b = 16'h5555;
        cycle();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("rst_mid_ready", 32'(s_in_ready), 32'd1);
        chk("rst_mid_valid", 32'(s_out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_mid_no_stale", 32'(s_out_valid), 32'd0);
        end
        $display("reset mid-operation sequence done at cycle %0d", cycles);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = pick();
            b         = pick();
            c_in      = 1'($urandom);
            op        = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            cycle();
        end
        chk("random_drain_empty", 32'(exp_q.size()), 32'd0);
        cycle();
        chk("random_idle_valid", 32'(s_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; legal values are multiples of 4 from 4 to 64.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, operand set offered.
REQ-005 SHALL have port in_ready, output, 1, block accepts the offered operand set this cycle.
REQ-006 SHALL have port a, input, WIDTH, operand A.
REQ-007 SHALL have port b, input, WIDTH, operand B.
REQ-008 SHALL have port c_in, input, 1, carry-in; used in add mode only.
REQ-009 SHALL have port op, input, 1, 0 = OP_ADD, 1 = OP_SUB.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-012 SHALL have port sum, output, WIDTH, result.
REQ-013 SHALL have port c_out, output, 1, carry out of the MSB; in subtract mode 1 means no borrow.
REQ-014 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-015 SHALL have port zero, output, 1, sum equals 0.

Function
REQ-016 SHALL accept an operand set when in_valid and in_ready are both 1; transfer to the output SHALL complete when out_valid and out_ready are both 1.
REQ-017 SHALL add as a + b + c_in in add mode, and as a + ~b + 1 in subtract mode, where c_in is ignored.
REQ-018 SHALL be a 2-stage pipeline:
  - S1 registers the operands, the effective B, the effective carry-in, and the per-4-bit-group generate and propagate signals.
  - S2 computes group carries by lookahead from the S1 registers, then registers sum, c_out, ovf and zero.
REQ-019 SHALL compute group propagate as the AND of bitwise a^b, and group generate by true carry-lookahead; each bit propagate SHALL be a XOR b, never a AND b.
REQ-020 SHALL present the result with out_valid high exactly 2 cycles after acceptance when there is no backpressure.
REQ-021 SHALL sustain one accepted operand set per cycle while out_ready is held at 1.
REQ-022 SHALL advance S2 when S2 is empty or out_ready=1, and S1 when S1 is empty or S2 advances; in_ready = !s1_valid | s1_advance, with no combinational path from in_valid.
REQ-023 SHALL hold sum, c_out, ovf and zero stable while out_valid=1 and out_ready=0.
REQ-024 SHALL deliver results in acceptance order, without loss or duplication.
REQ-025 SHALL, with both stages full and out_ready=0, drive in_ready=0.
REQ-026 SHALL, with both stages full and out_ready=1, accept a new operand set in the same cycle that the output is taken.
REQ-027 SHALL set ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb).
REQ-028 SHALL wrap the sum modulo 2^WIDTH, with the carry reported only on c_out.

Reset
REQ-029 SHALL, while rst_n=0 at a clock edge, clear s1_valid, out_valid, sum, c_out, ovf, zero and all S1 data registers to 0.
REQ-030 SHALL drop in-flight operations on reset mid-operation, with no result emitted for them.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst_n returns high.

Structure
REQ-032 SHALL take GROUP_W=4 and the op encoding constants OP_ADD and OP_SUB from shared package cla_pkg.
REQ-033 SHALL instantiate sub-module cla4_group WIDTH/4 times; cla4_group is purely combinational and produces the 4-bit group's g, p and sum from a, b and a carry-in.
REQ-034 SHALL contain no latches, and no logic on clk other than rising-edge registers.

Verification (WIDTH=16)
REQ-035 SHALL cover carry ripple: add 0x00FF + 0x0001, c_in=0 -> sum 0x0100, c_out 0, ovf 0, out_valid high 2 cycles after acceptance.
REQ-036 SHALL cover full wrap: add 0xFFFF + 0x0000, c_in=1 -> sum 0x0000, c_out 1, zero 1, ovf 0.
REQ-037 SHALL cover signed overflow: add 0x7FFF + 0x0001 -> sum 0x8000, ovf 1, c_out 0.
REQ-038 SHALL cover subtract with borrow: 0x0005 - 0x0007 with c_in=1 -> sum 0xFFFE, c_out 0, ovf 0; the c_in value must have no effect.
REQ-039 SHALL cover backpressure: 4 back-to-back operand sets with out_ready=0 -> 2 accepted, in_ready 0, outputs stable; then out_ready=1 -> all 4 results in order, one per cycle.
REQ-040 SHALL cover reset mid-operation: accept 2 operand sets, assert rst_n=0 for 1 cycle -> out_valid 0 and no stale result afterwards.
